// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus. It replays one command
// for a single cycle, waits RD_LATENCY cycles, then returns a registered response.
module data_bus_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a master holds req and its command stable until it sees gnt (a
  // one-cycle pulse), then drops req; exactly one rvalid pulse follows every gnt
  // unless reset intervenes. req is only looked at while the FSM is IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic        cmd_we_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic [3:0]  cmd_be_q;
  logic [2:0]  cnt_q;
  logic [31:0] resp_q;

  logic        arb_valid;
  logic        arb_win;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    arb_valid = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      arb_win = ~last_grant_q;
    end else begin
      arb_win = m1_req_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == LAT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      cnt_q        <= '0;
      resp_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            owner_q      <= arb_win;
            last_grant_q <= arb_win;
            cmd_we_q     <= arb_win ? m1_we_i    : m0_we_i;
            cmd_addr_q   <= arb_win ? m1_addr_i  : m0_addr_i;
            cmd_wdata_q  <= arb_win ? m1_wdata_i : m0_wdata_i;
            cmd_be_q     <= arb_win ? m1_be_i    : m0_be_i;
          end
        end
        ISSUE: cnt_q <= 3'd1;
        WAIT: begin
          if (cnt_q == LAT) begin
            cnt_q  <= '0;
            resp_q <= cmd_we_q ? 32'h0 : bus_rdata_i;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address/data/be lines keep the last command; only req/we are qualified by ISSUE.
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    bus_req_o   = (state_q == ISSUE);
    bus_we_o    = (state_q == ISSUE) & cmd_we_q;
    bus_addr_o  = cmd_addr_q;
    bus_wdata_o = cmd_wdata_q;
    bus_be_o    = cmd_be_q;
    if (state_q == ISSUE) begin
      if (owner_q) m1_gnt_o = 1'b1;
      else         m0_gnt_o = 1'b1;
    end
    if (state_q == RESP) begin
      if (owner_q) begin
        m1_rvalid_o = 1'b1;
        m1_rdata_o  = resp_q;
      end else begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = resp_q;
      end
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: two instances (RD_LATENCY 1 and 3) driven by random
// masters, checked cycle by cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_data_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done [2];

  task automatic check(input string name, input int g, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  // Bus read data is a known function of the cycle number, so the model can
  // predict what a read must return without looking at the DUT.
  function automatic logic [31:0] rd_pattern(input int g, input int c);
    return (32'(c) * 32'h9E3779B1) ^ ((g == 0) ? 32'h5A5A0F0F : 32'hC3C33C3C);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rstn;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic [31:0] rdata [2];
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic [1:0]  dbg_state;

    int          cyc = 0;
    bit          check_en = 1'b0;
    // gnt entry: {cycle[31:0], master, we, addr, wdata, be}
    logic [101:0] gnt_q[$];
    // rsp entry: {cycle[31:0], master, rdata}
    logic [64:0]  rsp_q[$];
    logic [67:0]  exp_cmd;

    data_bus_arbiter #(.RD_LATENCY(LAT)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
      .m0_be_i(be[0]), .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]),
      .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
      .m1_be_i(be[1]), .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
      .bus_wdata_o(bus_wdata), .bus_be_o(bus_be), .bus_rdata_i(bus_rdata),
      .dbg_state_o(dbg_state)
    );

    // Reference model: a bus that is busy for LAT+3 cycles per transaction,
    // with round-robin tie break and reset discarding anything outstanding.
    initial begin : model
      int   free_at;
      logic last_g;
      logic w;
      free_at   = 0;
      last_g    = 1'b1;
      exp_cmd   = '0;
      bus_rdata = rd_pattern(g, 0);
      forever begin
        @(posedge clk);
        if (!rstn) begin
          gnt_q.delete();
          rsp_q.delete();
          free_at  = cyc + 1;
          last_g   = 1'b1;
          exp_cmd  = '0;
          check_en = 1'b1;
        end else if (cyc >= free_at && (req[0] || req[1])) begin
          w       = (req[0] && req[1]) ? ~last_g : req[1];
          last_g  = w;
          exp_cmd = {addr[w], wdata[w], be[w]};
          gnt_q.push_back({32'(cyc + 1), w, we[w], addr[w], wdata[w], be[w]});
          rsp_q.push_back({32'(cyc + 2 + LAT), w,
                           we[w] ? 32'h0 : rd_pattern(g, cyc + 1 + LAT)});
          free_at = cyc + LAT + 3;
        end
        cyc++;
        #1 bus_rdata = rd_pattern(g, cyc);
      end
    end

    initial begin : monitor
      logic [101:0] ge;
      logic [64:0]  re;
      logic [3:0]   exp_iss;
      logic [65:0]  exp_rsp;
      forever begin
        @(negedge clk);
        if (check_en) begin
          exp_iss = '0;
          if (gnt_q.size() > 0 && gnt_q[0][101:70] == 32'(cyc)) begin
            ge      = gnt_q.pop_front();
            exp_iss = {~ge[69], ge[69], 1'b1, ge[68]};
          end
          check("issue", g, 128'({gnt[0], gnt[1], bus_req, bus_we}), 128'(exp_iss));
          check("bus_cmd", g, 128'({bus_addr, bus_wdata, bus_be}), 128'(exp_cmd));
          exp_rsp = '0;
          if (rsp_q.size() > 0 && rsp_q[0][64:33] == 32'(cyc)) begin
            re      = rsp_q.pop_front();
            exp_rsp = {~re[32], re[32], re[32] ? 32'h0 : re[31:0], re[32] ? re[31:0] : 32'h0};
          end
          check("response", g, 128'({rvalid[0], rvalid[1], rdata[0], rdata[1]}),
                128'(exp_rsp));
        end
      end
    end

    task automatic new_cmd(input int m);
      we[m]    = 1'($urandom_range(0, 1));
      addr[m]  = $urandom();
      wdata[m] = $urandom();
      be[m]    = 4'($urandom_range(0, 15));
    endtask

    // Masters: a held-tie phase, then random requests, stray pulses, held-over
    // requests after gnt, and occasional single-cycle resets.
    initial begin : driver
      bit pend [2];
      bit sticky;
      rstn = 1'b0;
      for (int m = 0; m < 2; m++) begin
        req[m]  = 1'b0;
        pend[m] = 1'b0;
        new_cmd(m);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        sticky = (n < 300);
        rstn   = 1'b1;
        if (!sticky && $urandom_range(0, 59) == 0) rstn = 1'b0;
        for (int m = 0; m < 2; m++) begin
          if (gnt[m]) pend[m] = 1'b0;
          if (pend[m]) begin
            req[m] = 1'b1;
          end else if (sticky || $urandom_range(0, 3) == 0) begin
            new_cmd(m);
            pend[m] = 1'b1;
            req[m]  = 1'b1;
          end else if ($urandom_range(0, 15) == 0) begin
            new_cmd(m);
            req[m] = 1'b1;
          end else begin
            req[m] = 1'b0;
          end
        end
      end
      @(negedge clk);
      rstn   = 1'b1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (LAT + 6) @(negedge clk);
      check("drain", g, 128'(gnt_q.size() + rsp_q.size()), 128'(0));
      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
